// File: rtl/qucs_netlist_emitter.sv
// Turns one binary R/C/L record into one qucsator netlist line, streamed out as ASCII bytes.
// First byte appears VAL_W+1 cycles after acceptance, then one byte per cycle while out_ready is high.
module qucs_netlist_emitter #(
    parameter int IDX_W = 8,
    parameter int VAL_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_type,
    input  logic [IDX_W-1:0] in_inst,
    input  logic [IDX_W-1:0] in_p,
    input  logic [IDX_W-1:0] in_n,
    input  logic [VAL_W-1:0] in_val,
    input  logic [2:0]       in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             err,
    output logic [15:0]      rec_count
);
    localparam logic [3:0] IDLE = 4'd0, CONV = 4'd1, EMIT_TYPE = 4'd2, EMIT_INST = 4'd3,
                           EMIT_P = 4'd4, EMIT_N = 4'd5, EMIT_VAL = 4'd6, EMIT_UNIT = 4'd7,
                           EMIT_EOL = 4'd8, ERR = 4'd9;

    logic [3:0]       state;
    logic [4:0]       cnt;
    logic [2:0]       pos, dig;
    logic [1:0]       typ;
    logic [2:0]       exq;
    logic [VAL_W-1:0] sh_i, sh_p, sh_n, sh_v;
    logic [19:0]      b_i, b_p, b_n, b_v;
    logic [7:0]       tch;
    logic             adv;

    function automatic logic [19:0] dd_step(input logic [19:0] b, input logic bit_in);
        logic [19:0] t;
        t = b;
        for (int k = 0; k < 5; k++)
            if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
        return {t[18:0], bit_in};
    endfunction

    // Index of the most significant non-zero digit; 0 for a zero value so "0" still prints
    function automatic logic [2:0] msd(input logic [19:0] b);
        logic [2:0] m;
        m = 3'd0;
        for (int k = 1; k < 5; k++)
            if (b[4*k +: 4] != 4'd0) m = 3'(k);
        return m;
    endfunction

    function automatic logic [7:0] dch(input logic [19:0] b, input logic [2:0] d);
        logic [3:0] nb;
        case (d)
            3'd0:    nb = b[3:0];
            3'd1:    nb = b[7:4];
            3'd2:    nb = b[11:8];
            3'd3:    nb = b[15:12];
            default: nb = b[19:16];
        endcase
        return 8'h30 + {4'h0, nb};
    endfunction

    function automatic logic [7:0] node_byte(input logic [19:0] b, input logic [2:0] ps, input logic [2:0] d);
        logic [7:0] c;
        if (b == 20'd0) begin
            case (ps)
                3'd0:    c = "g";
                3'd1:    c = "n";
                3'd2:    c = "d";
                default: c = " ";
            endcase
        end else begin
            case (ps)
                3'd0:    c = "_";
                3'd1:    c = "n";
                3'd2:    c = "e";
                3'd3:    c = "t";
                3'd4:    c = dch(b, d);
                default: c = " ";
            endcase
        end
        return c;
    endfunction

    assign in_ready  = (state == IDLE);
    assign err       = (state == ERR);
    assign out_valid = (state >= EMIT_TYPE) && (state <= EMIT_EOL);
    assign adv       = out_valid && out_ready;
    assign tch       = (typ == 2'd0) ? "R" : (typ == 2'd1) ? "C" : "L";

    always_comb begin
        out_data = 8'h00;
        case (state)
            EMIT_TYPE: out_data = (pos == 3'd1) ? ":" : tch;
            EMIT_INST: out_data = (pos == 3'd0) ? dch(b_i, dig) : " ";
            EMIT_P:    out_data = node_byte(b_p, pos, dig);
            EMIT_N:    out_data = node_byte(b_n, pos, dig);
            EMIT_VAL: begin
                case (pos)
                    3'd0:    out_data = tch;
                    3'd1:    out_data = "=";
                    3'd2:    out_data = "\"";
                    3'd3:    out_data = dch(b_v, dig);
                    default: out_data = " ";
                endcase
            end
            EMIT_UNIT: begin
                if (pos == 3'd0) begin
                    case (exq)
                        3'd0:    out_data = "f";
                        3'd1:    out_data = "p";
                        3'd2:    out_data = "n";
                        3'd3:    out_data = "u";
                        3'd4:    out_data = "m";
                        3'd6:    out_data = "k";
                        3'd7:    out_data = "M";
                        default: out_data = 8'h00;
                    endcase
                end else if (typ == 2'd0) begin
                    case (pos)
                        3'd1:    out_data = "O";
                        3'd2:    out_data = "h";
                        3'd3:    out_data = "m";
                        default: out_data = "\"";
                    endcase
                end else begin
                    out_data = (pos == 3'd1) ? ((typ == 2'd1) ? "F" : "H") : "\"";
                end
            end
            EMIT_EOL:  out_data = 8'h0A;
            default:   out_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; cnt <= '0; pos <= '0; dig <= '0; typ <= '0; exq <= '0;
            sh_i <= '0; sh_p <= '0; sh_n <= '0; sh_v <= '0;
            b_i <= '0; b_p <= '0; b_n <= '0; b_v <= '0;
            rec_count <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    typ <= in_type; exq <= in_exp; cnt <= '0;
                    sh_i <= VAL_W'(in_inst); sh_p <= VAL_W'(in_p); sh_n <= VAL_W'(in_n); sh_v <= in_val;
                    b_i <= '0; b_p <= '0; b_n <= '0; b_v <= '0;
                    state <= (in_type == 2'd3) ? ERR : CONV;
                end
                ERR: state <= IDLE;
                CONV: begin
                    b_i <= dd_step(b_i, sh_i[VAL_W-1]); sh_i <= sh_i << 1;
                    b_p <= dd_step(b_p, sh_p[VAL_W-1]); sh_p <= sh_p << 1;
                    b_n <= dd_step(b_n, sh_n[VAL_W-1]); sh_n <= sh_n << 1;
                    b_v <= dd_step(b_v, sh_v[VAL_W-1]); sh_v <= sh_v << 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(VAL_W - 1)) begin
                        state <= EMIT_TYPE;
                        pos   <= '0;
                    end
                end
                default: if (adv) begin
                    case (state)
                        EMIT_TYPE:
                            if (pos == 3'd2) begin state <= EMIT_INST; pos <= '0; dig <= msd(b_i); end
                            else pos <= pos + 3'd1;
                        EMIT_INST:
                            if (pos != 3'd0) begin state <= EMIT_P; pos <= '0; dig <= msd(b_p); end
                            else if (dig == 3'd0) pos <= 3'd1;
                            else dig <= dig - 3'd1;
                        EMIT_P, EMIT_N: begin
                            // Digit position loops on pos 4 until the units digit is out
                            if ((state == EMIT_P ? b_p : b_n) != 20'd0 && pos == 3'd4) begin
                                if (dig == 3'd0) pos <= 3'd5;
                                else dig <= dig - 3'd1;
                            end else if (pos == (((state == EMIT_P ? b_p : b_n) == 20'd0) ? 3'd3 : 3'd5)) begin
                                pos <= '0;
                                if (state == EMIT_P) begin state <= EMIT_N; dig <= msd(b_n); end
                                else begin state <= EMIT_VAL; dig <= msd(b_v); end
                            end else pos <= pos + 3'd1;
                        end
                        EMIT_VAL:
                            if (pos == 3'd3) begin
                                if (dig == 3'd0) pos <= 3'd4;
                                else dig <= dig - 3'd1;
                            end else if (pos == 3'd4) begin
                                state <= EMIT_UNIT;
                                pos   <= (exq == 3'd5) ? 3'd1 : 3'd0;
                            end else pos <= pos + 3'd1;
                        EMIT_UNIT:
                            if (pos == ((typ == 2'd0) ? 3'd4 : 3'd2)) state <= EMIT_EOL;
                            else pos <= pos + 3'd1;
                        EMIT_EOL: begin
                            state     <= IDLE;
                            rec_count <= rec_count + 16'd1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qucs_netlist_emitter.sv
// Scoreboard bench: stimulus queues expected bytes, a negedge monitor pops and compares each transfer.
module tb_qucs_netlist_emitter;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready;
    logic [1:0]  in_type = 0;
    logic [7:0]  in_inst = 0, in_p = 0, in_n = 0;
    logic [15:0] in_val = 0;
    logic [2:0]  in_exp = 0;
    logic        out_valid, out_ready = 1, err;
    logic [7:0]  out_data;
    logic [15:0] rec_count;

    int checks = 0, errors = 0, rx_cnt = 0, exp_cnt = 0;
    bit rand_rdy = 0;
    logic [7:0] sb[$];

    qucs_netlist_emitter #(.IDX_W(8), .VAL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_inst(in_inst), .in_p(in_p), .in_n(in_n), .in_val(in_val), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err),
        .rec_count(rec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: compares every transferred byte and checks data is held during stalls
    initial begin
        bit stalled = 0;
        logic [7:0] held = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (stalled) chk("stall_hold", out_data, held);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte: got %02h required none", out_data);
                    end else begin
                        chk("byte", out_data, sb.pop_front());
                    end
                    rx_cnt++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = out_data;
                end
            end else stalled = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_rec(input logic [1:0] t, input logic [7:0] i, p, n,
                            input logic [15:0] v, input logic [2:0] e, input string s);
        int c = 0;
        for (int k = 0; k < s.len(); k++) sb.push_back(s[k]);
        while (!in_ready && c < 200) begin @(posedge clk); #1; c++; end
        chk("in_ready_wait", in_ready, 1);
        in_type = t; in_inst = i; in_p = p; in_n = n; in_val = v; in_exp = e; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        chk("in_ready_drop", in_ready, 0);
    endtask

    task automatic finish_line(input int len, input bit full_rate);
        int c = 0, nv = 0, first = -1;
        while (!in_ready && c < 3000) begin
            @(posedge clk); #1; c++;
            if (out_valid) begin nv++; if (first < 0) first = c; end
        end
        chk("line_done", in_ready, 1);
        chk("queue_empty", sb.size(), 0);
        if (full_rate) begin
            chk("valid_cycles", nv, len);
            chk("latency_ok", (first >= 1 && first <= 18), 1);
        end
        exp_cnt++;
        chk("rec_count", rec_count, exp_cnt);
    endtask

    initial begin
        string l1, l2, l3, lb;
        int c, base;
        l1 = "R:R1 _net1 gnd R=\"50 Ohm\"\n";
        l2 = "C:C0 _net12 _net255 C=\"0 nF\"\n";
        l3 = "L:L255 gnd gnd L=\"65535 MH\"\n";
        lb = "R:R2 _net3 _net4 R=\"12345 mOhm\"\n";

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err, 0);
        chk("rst_rec_count", rec_count, 0);
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;

        send_rec(2'd0, 8'd1, 8'd1, 8'd0, 16'd50, 3'd5, l1);
        finish_line(l1.len(), 1);
        chk("len_l1", l1.len(), 26);
        send_rec(2'd1, 8'd0, 8'd12, 8'd255, 16'd0, 3'd2, l2);
        finish_line(l2.len(), 1);
        send_rec(2'd2, 8'd255, 8'd0, 8'd0, 16'd65535, 3'd7, l3);
        finish_line(l3.len(), 1);

        rand_rdy = 1;
        send_rec(2'd0, 8'd1, 8'd1, 8'd0, 16'd50, 3'd5, l1);
        finish_line(l1.len(), 0);
        rand_rdy = 0;
        @(posedge clk); #1;

        send_rec(2'd3, 8'd7, 8'd7, 8'd7, 16'd7, 3'd1, "");
        chk("err_pulse", err, 1);
        @(posedge clk); #1;
        chk("err_cleared", err, 0);
        chk("err_in_ready", in_ready, 1);
        chk("err_rec_count", rec_count, exp_cnt);
        repeat (5) @(posedge clk);
        #1;

        send_rec(2'd0, 8'd1, 8'd1, 8'd0, 16'd50, 3'd5, l1);
        finish_line(l1.len(), 1);
        base = rx_cnt;
        send_rec(2'd0, 8'd2, 8'd3, 8'd4, 16'd12345, 3'd4, lb);
        c = 0;
        while (rx_cnt < base + 21 && c < 500) begin @(posedge clk); #1; c++; end
        chk("reached_val", (rx_cnt >= base + 21), 1);
        rst_n = 0;
        sb.delete();
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_rec_count", rec_count, 0);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk); #1; rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_resume", out_valid, 0);
        exp_cnt = 0;
        send_rec(2'd0, 8'd1, 8'd1, 8'd0, 16'd50, 3'd5, l1);
        finish_line(l1.len(), 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qucs_netlist_emitter.md
Name: qucs_netlist_emitter

Overview:
- Writer side of the qucsator lumped-component netlist mapping: takes binary component records and streams the matching qucsator netlist line as ASCII bytes.
- Used by the digital co-simulation harness to dump R/C/L instances back into qucsator form.
- One record in, one newline-terminated line out, over valid/ready byte handshakes on both sides.

Parameters:
- IDX_W, 8, width of instance index and node indices (decimal print fixed at max 3 digits; IDX_W must be ≤ 8).
- VAL_W, 16, width of value mantissa (max 5 decimal digits; VAL_W must be ≤ 16).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  record valid.
- in_ready  out  1  emitter can accept a record.
- in_type  in  2  0=R, 1=C, 2=L, 3=invalid.
- in_inst  in  IDX_W  instance number.
- in_p  in  IDX_W  positive node; 0 means gnd.
- in_n  in  IDX_W  negative node; 0 means gnd.
- in_val  in  VAL_W  unsigned value mantissa.
- in_exp  in  3  SI prefix code: 0 f, 1 p, 2 n, 3 u, 4 m, 5 none, 6 k, 7 M.
- out_valid  out  1  byte valid.
- out_ready  in  1  sink accepts byte.
- out_data  out  8  ASCII byte.
- err  out  1  one-cycle pulse on an invalid record.
- rec_count  out  16  count of fully emitted records.

Behaviour:
- Reset (async assert, sync release):
  - in_ready=1, out_valid=0, out_data=0, err=0, rec_count=0.
  - FSM returns to IDLE.
  - All conversion state is cleared.
- Record acceptance:
  - A record is accepted on a clk edge with in_valid && in_ready.
  - All in_* fields are registered at that edge.
  - in_ready drops the next cycle and stays 0 until the edge at which the final '\n' is accepted. It rises on the cycle after that edge.
- Invalid record (in_type=3):
  - The record is accepted.
  - err=1 for exactly the cycle after acceptance; no bytes are emitted; rec_count is unchanged.
  - in_ready returns to 1 the cycle after the err pulse.
- Line format, where T is 'R', 'C' or 'L' and U is "Ohm", "F" or "H" respectively:
  - T ':' T inst ' ' nodeP ' ' nodeN ' ' T '=' '"' val ' ' prefix U '"' '\n'.
  - Node field: index 0 prints "gnd"; otherwise "_net" followed by the decimal index.
  - Decimal fields have leading zeros suppressed; the value 0 prints "0".
  - Prefix code 5 emits no character; the other codes emit one character each (u for micro).
- FSM states: IDLE, CONV, EMIT_TYPE, EMIT_INST, EMIT_P, EMIT_N, EMIT_VAL, EMIT_UNIT, EMIT_EOL, ERR.
  - IDLE→CONV on a valid record; IDLE→ERR on type 3.
  - CONV runs a sequential binary-to-BCD conversion (shift-add-3) of inst, p, n and val. It takes VAL_W cycles, with all four fields converted in parallel.
  - CONV→EMIT_TYPE, then the EMIT_* states in the order listed.
  - A per-field digit counter skips leading zeros.
  - EMIT_EOL → IDLE when '\n' is accepted.
  - ERR → IDLE after one cycle.
- Latency: the first byte (out_valid=1) appears no later than VAL_W+2 cycles after acceptance.
- Output handshake:
  - A byte transfers on an edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_data is held stable and out_valid stays 1.
  - With out_ready held at 1, the emitter sends one byte per cycle with no bubbles between fields.
- rec_count increments on the edge where '\n' transfers, and wraps from 0xFFFF to 0.
- Reset asserted mid-line aborts the line immediately; no partial-line completion occurs after release.
- in_valid while in_ready=0 is ignored; the source must hold its record.

Test Plan:
- R, inst 1, p 1, n 0, val 50, exp 5, out_ready=1 → exactly the 26 bytes `R:R1 _net1 gnd R="50 Ohm"\n`, back-to-back; rec_count=1; in_ready high the cycle after '\n'.
- C, inst 0, p 12, n 255, val 0, exp 2 → `C:C0 _net12 _net255 C="0 nF"\n`.
- L, inst 255, p 0, n 0, val 65535, exp 7 → `L:L255 gnd gnd L="65535 MH"\n`.
- Repeat the first record with out_ready driven by a pseudo-random pattern (≈50% duty) → identical byte sequence; no drops or duplicates; out_data stable during every stall.
- in_type=3 with any fields → err high for one cycle; out_valid never rises; rec_count unchanged; in_ready back to 1 within 2 cycles.
- Two records: drop rst_n for one cycle while the second record is emitting its val field → out_valid=0 immediately and rec_count=0. A following fresh record then emits a complete, correct line with rec_count=1.
